// File: rtl/ofdm_tx_cp_framer_if.sv
// Sample-stream bundle for the OFDM TX cyclic-prefix framer: symbol input with ready/valid handshake,
// framed output as a one-cycle valid pulse per sample, and the underrun flag.
interface ofdm_tx_cp_framer_if #(
  parameter int W = 12
);
  logic [W-1:0] in_i;
  logic [W-1:0] in_q;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] tx_data_i;
  logic [W-1:0] tx_data_q;
  logic         tx_data_valid;
  logic         tx_underrun;

  modport master (
    output in_i, in_q, in_valid,
    input  in_ready, tx_data_i, tx_data_q, tx_data_valid, tx_underrun
  );

  modport slave (
    input  in_i, in_q, in_valid,
    output in_ready, tx_data_i, tx_data_q, tx_data_valid, tx_underrun
  );
endinterface

// File: rtl/ofdm_tx_cp_framer.sv
// Ping-pong symbol store re-emitted with a cyclic prefix, one sample per strobe, output one cycle after the tick;
// in_ready drops while both buffers are full. OFDM_TX_ZERO_FILL_EN emits zero samples on idle ticks.
module ofdm_tx_cp_framer #(
  parameter int sample_bit_width_g = 12,
  parameter int symbol_length_g    = 64,
  parameter int guard_length_g     = 16,
  parameter int strobe_div_g       = 25
) (
  input  logic                  sys_clk,
  input  logic                  sys_rstn,
  input  logic                  sys_init,
  ofdm_tx_cp_framer_if.slave    bus
);

  localparam int W  = sample_bit_width_g;
  localparam int IW = $clog2(symbol_length_g);
  localparam int CW = $clog2(strobe_div_g + 1);

  localparam logic [IW-1:0] IDX_LAST  = IW'(symbol_length_g - 1);
  localparam logic [IW-1:0] PFX_START = IW'(symbol_length_g - guard_length_g);
  localparam logic [IW-1:0] PFX_NEXT  = IW'(symbol_length_g - guard_length_g + 1);
  localparam logic [CW-1:0] CNT_TOP   = CW'(strobe_div_g);

  typedef enum logic [1:0] {IDLE, PREFIX, BODY} state_t;

  logic [2*W-1:0] mem [0:2*symbol_length_g-1];

  logic [CW-1:0] cnt;
  logic          tick;

  logic [1:0]    full, full_nxt;
  logic          wr_buf, wr_buf_nxt;
  logic [IW-1:0] wr_idx, wr_idx_nxt;
  logic          ready_q;
  logic          accept;

  state_t        state;
  logic          rd_buf;
  logic [IW-1:0] rd_idx;
  logic          release_buf;
  logic [IW:0]   rd_addr;
  logic [2*W-1:0] rd_dat;
  logic          sent;
  logic          underrun;
  logic [W-1:0]  out_i, out_q;
  logic          out_valid;

  assign tick        = (cnt == CNT_TOP);
  assign accept      = bus.in_valid & ready_q;
  assign release_buf = tick && (state == BODY) && (rd_idx == IDX_LAST);
  assign rd_addr     = {rd_buf, (state == IDLE) ? PFX_START : rd_idx};
  assign rd_dat      = mem[rd_addr];

  assign bus.in_ready      = ready_q;
  assign bus.tx_data_i     = out_i;
  assign bus.tx_data_q     = out_q;
  assign bus.tx_data_valid = out_valid;
  assign bus.tx_underrun   = underrun;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt <= '0;
    end else if (sys_init) begin
      cnt <= '0;
    end else begin
      cnt <= tick ? CW'(1) : cnt + CW'(1);
    end
  end

  // Release and fill always target different buffers, so both updates can land together.
  always_comb begin
    full_nxt   = full;
    wr_buf_nxt = wr_buf;
    wr_idx_nxt = wr_idx;
    if (release_buf) full_nxt[rd_buf] = 1'b0;
    if (accept) begin
      if (wr_idx == IDX_LAST) begin
        full_nxt[wr_buf] = 1'b1;
        wr_buf_nxt       = ~wr_buf;
        wr_idx_nxt       = '0;
      end else begin
        wr_idx_nxt = wr_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      full    <= '0;
      wr_buf  <= 1'b0;
      wr_idx  <= '0;
      ready_q <= 1'b1;
    end else if (sys_init) begin
      full    <= '0;
      wr_buf  <= 1'b0;
      wr_idx  <= '0;
      ready_q <= 1'b1;
    end else begin
      full    <= full_nxt;
      wr_buf  <= wr_buf_nxt;
      wr_idx  <= wr_idx_nxt;
      ready_q <= ~full_nxt[wr_buf_nxt];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (accept) mem[{wr_buf, wr_idx}] <= {bus.in_i, bus.in_q};
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state     <= IDLE;
      rd_buf    <= 1'b0;
      rd_idx    <= '0;
      sent      <= 1'b0;
      underrun  <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (sys_init) begin
      state     <= IDLE;
      rd_buf    <= 1'b0;
      rd_idx    <= '0;
      sent      <= 1'b0;
      underrun  <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (full[rd_buf]) begin
              out_i     <= rd_dat[2*W-1:W];
              out_q     <= rd_dat[W-1:0];
              out_valid <= 1'b1;
              if (PFX_START == IDX_LAST) begin
                state  <= BODY;
                rd_idx <= '0;
              end else begin
                state  <= PREFIX;
                rd_idx <= PFX_NEXT;
              end
            end else begin
              if (sent) underrun <= 1'b1;
`ifdef OFDM_TX_ZERO_FILL_EN
              out_i     <= '0;
              out_q     <= '0;
              out_valid <= 1'b1;
`endif
            end
          end
          PREFIX: begin
            out_i     <= rd_dat[2*W-1:W];
            out_q     <= rd_dat[W-1:0];
            out_valid <= 1'b1;
            if (rd_idx == IDX_LAST) begin
              state  <= BODY;
              rd_idx <= '0;
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
          BODY: begin
            out_i     <= rd_dat[2*W-1:W];
            out_q     <= rd_dat[W-1:0];
            out_valid <= 1'b1;
            if (rd_idx == IDX_LAST) begin
              sent   <= 1'b1;
              rd_buf <= ~rd_buf;
              // Only a buffer already full before this tick chains on without a gap.
              if (full[~rd_buf]) begin
                state  <= PREFIX;
                rd_idx <= PFX_START;
              end else begin
                state  <= IDLE;
                rd_idx <= '0;
              end
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
          default: begin
            state  <= IDLE;
            rd_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule
